// File: rtl/dummy_adc_pkg.sv
// dummy_adc_pkg: slot pin indices, frame sizes and FSM states shared by the capture path
package dummy_adc_pkg;
   localparam int SLOT_DATA = 0;
   localparam int SLOT_LRCK = 1;
   localparam int SLOT_BCK = 2;
   localparam int FRAME_MONO = 16;
   localparam int FRAME_STEREO = 32;
   typedef enum logic [1:0] {IDLE, SHIFT, CHECK, WRITE} state_t;
endpackage

// File: rtl/dummy_adc_if.sv
// dummy_adc_if: byte-wide FIFO write port with the pointers needed to judge free space
interface dummy_adc_if #(parameter int W = 11);
   logic fifo_clk;
   logic fifo_write;
   logic [7:0] fifo_data;
   logic [W-1:0] fifo_addr_in;
   logic [W-1:0] fifo_addr_out;
   modport master(output fifo_clk, fifo_data, fifo_write, input fifo_addr_in, fifo_addr_out);
   modport slave(input fifo_clk, fifo_data, fifo_write, output fifo_addr_in, fifo_addr_out);
endinterface

// File: rtl/dummy_adc_delay_reg.sv
// delay_reg: NUM_CYCLES-deep flop chain, used as the multi-stage synchronizer on slot pins
module delay_reg #(
   parameter int NUM_BITS = 1,
   parameter int NUM_CYCLES = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_BITS-1:0] d,
   output logic [NUM_BITS-1:0] q
);
   logic [NUM_BITS-1:0] stage [NUM_CYCLES];
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_CYCLES; i++) stage[i] <= '0;
      end else begin
         stage[0] <= d;
         for (int i = 1; i < NUM_CYCLES; i++) stage[i] <= stage[i-1];
      end
   end
   assign q = stage[NUM_CYCLES-1];
endmodule

// File: rtl/dummy_adc.sv
// dummy_adc: deserialize the slot audio stream into 16/32-bit frames and burst them
// into the slot FIFO LSB byte first, dropping frames that do not fit
module dummy_adc
   import dummy_adc_pkg::*;
#(
   parameter int FIFO_ADDR_WIDTH = 11,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  slot_data,
   input  logic        direction,
   input  logic        channels,
   dummy_adc_if.master fifo,
   output logic [7:0]  overflow_count,
   output logic [7:0]  sync_error_count
);
   state_t state, next;
   logic [2:0] sync;
   logic bck_d, lrck_prev, stereo;
   logic [5:0] bit_cnt;
   logic [1:0] byte_idx;
   logic [31:0] shreg;
   logic [7:0] data_q;
   logic [FIFO_ADDR_WIDTH-1:0] used, free;
   logic bck_rise, frame_start, room, last_bit, last_byte, unused_pins;

   assign unused_pins = ^slot_data[5:3];
   delay_reg #(.NUM_BITS(3), .NUM_CYCLES(SYNC_STAGES)) sync_i (
      .clk(clk), .reset(reset), .d(slot_data[2:0]), .q(sync)
   );

   assign bck_rise = sync[SLOT_BCK] & ~bck_d;
   assign frame_start = bck_rise & sync[SLOT_LRCK] & ~lrck_prev;
   assign used = fifo.fifo_addr_in - fifo.fifo_addr_out;
   // 2^W-1-used is simply the bitwise complement in W bits
   assign free = ~used;
   assign room = free >= FIFO_ADDR_WIDTH'(stereo ? FRAME_STEREO / 8 : FRAME_MONO / 8);
   assign last_bit = bit_cnt == 6'((stereo ? FRAME_STEREO : FRAME_MONO) - 1);
   assign last_byte = byte_idx == 2'((stereo ? FRAME_STEREO : FRAME_MONO) / 8 - 1);

   assign fifo.fifo_clk = clk;
   assign fifo.fifo_write = state == WRITE;
   assign fifo.fifo_data = state == WRITE ? shreg[7:0] : data_q;

   always_comb begin
      next = state;
      case (state)
         IDLE:    next = direction && frame_start ? SHIFT : IDLE;
         SHIFT:   next = !direction ? IDLE : (bck_rise && !frame_start && last_bit) ? CHECK : SHIFT;
         CHECK:   next = direction && room ? WRITE : IDLE;
         WRITE:   next = last_byte ? IDLE : WRITE;
         default: next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         bck_d <= 1'b0;
         lrck_prev <= 1'b0;
         stereo <= 1'b0;
         bit_cnt <= '0;
         byte_idx <= '0;
         shreg <= '0;
         data_q <= '0;
         overflow_count <= '0;
         sync_error_count <= '0;
      end else begin
         state <= next;
         bck_d <= sync[SLOT_BCK];
         if (bck_rise) lrck_prev <= sync[SLOT_LRCK];
         if (frame_start && direction && (state == IDLE || state == SHIFT)) begin
            shreg <= {31'b0, sync[SLOT_DATA]};
            bit_cnt <= 6'd1;
            stereo <= channels;
         end else if (state == SHIFT && bck_rise) begin
            shreg[bit_cnt[4:0]] <= sync[SLOT_DATA];
            bit_cnt <= bit_cnt + 6'd1;
         end
         // the burst drains the shift register a byte per cycle, LSB byte first
         if (state == WRITE) begin
            shreg <= {8'h00, shreg[31:8]};
            data_q <= shreg[7:0];
         end
         byte_idx <= state == WRITE ? byte_idx + 2'd1 : 2'd0;
         if (state == SHIFT && direction && frame_start && sync_error_count != 8'hFF)
            sync_error_count <= sync_error_count + 8'd1;
         if (state == CHECK && direction && !room && overflow_count != 8'hFF)
            overflow_count <= overflow_count + 8'd1;
      end
   end
endmodule
